// File: rtl/instr_fetch_unit_if.sv
// Fetch-stage bundle: run control, instruction memory port, redirect input and decode handshake.
interface instr_fetch_unit_if #(
    parameter int unsigned ADDR_W = 2,
    parameter int unsigned DATA_W = 32
);
    logic              run;
    logic [ADDR_W-1:0] im_addr;
    logic              im_cs;
    logic [DATA_W-1:0] im_data;
    logic              br_valid;
    logic [ADDR_W-1:0] br_target;
    logic              if_valid;
    logic              if_ready;
    logic [DATA_W-1:0] if_instr;
    logic [ADDR_W-1:0] if_pc;
    logic              halted;

    modport master (
        input  run, im_data, br_valid, br_target, if_ready,
        output im_addr, im_cs, if_valid, if_instr, if_pc, halted
    );

    modport slave (
        output run, im_data, br_valid, br_target, if_ready,
        input  im_addr, im_cs, if_valid, if_instr, if_pc, halted
    );
endinterface

// File: rtl/instr_fetch_unit.sv
// Fetch stage: owns the PC, selects instruction memory on capture cycles and
// holds one fetched word for decode behind a valid/ready handshake.
module instr_fetch_unit #(
    parameter int unsigned ADDR_W    = 2,
    parameter int unsigned DATA_W    = 32,
    parameter int unsigned NUM_INSTR = 4,
    parameter int unsigned WRAP      = 1
) (
    input  logic                clk,
    input  logic                rst,
    instr_fetch_unit_if.master  bus
);
    localparam logic [ADDR_W-1:0] LAST_PC = ADDR_W'(NUM_INSTR - 1);

    typedef enum logic [1:0] {IDLE, FETCH, HALT} state_e;

    state_e            state_q, state_d;
    logic [ADDR_W-1:0] pc_q, pc_d;
    logic              if_valid_q, if_valid_d;
    logic [DATA_W-1:0] if_instr_q, if_instr_d;
    logic [ADDR_W-1:0] if_pc_q, if_pc_d;
    logic              halted_q, halted_d;
    logic              accept_c, space_c, load_c;
    logic [ADDR_W-1:0] next_pc_c;

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= IDLE;
            pc_q       <= '0;
            if_valid_q <= 1'b0;
            if_instr_q <= '0;
            if_pc_q    <= '0;
            halted_q   <= 1'b0;
        end else begin
            state_q    <= state_d;
            pc_q       <= pc_d;
            if_valid_q <= if_valid_d;
            if_instr_q <= if_instr_d;
            if_pc_q    <= if_pc_d;
            halted_q   <= halted_d;
        end
    end

    always_comb begin
        state_d    = state_q;
        pc_d       = pc_q;
        if_valid_d = if_valid_q;
        if_instr_d = if_instr_q;
        if_pc_d    = if_pc_q;
        load_c     = 1'b0;
        accept_c   = if_valid_q & bus.if_ready;
        space_c    = !if_valid_q | bus.if_ready;
        next_pc_c  = (pc_q == LAST_PC) ? '0 : pc_q + ADDR_W'(1);

        case (state_q)
            IDLE: begin
                if (bus.br_valid) begin
                    pc_d       = bus.br_target;
                    if_valid_d = 1'b0;
                end else begin
                    if (accept_c) if_valid_d = 1'b0;
                    if (bus.run)  state_d    = FETCH;
                end
            end
            FETCH: begin
                // A redirect drops the held word even if decode takes it this cycle
                if (bus.br_valid) begin
                    pc_d       = bus.br_target;
                    if_valid_d = 1'b0;
                end else if (!bus.run) begin
                    state_d = IDLE;
                    if (accept_c) if_valid_d = 1'b0;
                end else if (space_c) begin
                    load_c     = 1'b1;
                    if_instr_d = bus.im_data;
                    if_pc_d    = pc_q;
                    if_valid_d = 1'b1;
                    pc_d       = next_pc_c;
                    if (pc_q == LAST_PC && WRAP == 0) state_d = HALT;
                end
            end
            HALT: begin
                if (bus.br_valid) begin
                    pc_d       = bus.br_target;
                    if_valid_d = 1'b0;
                    state_d    = bus.run ? FETCH : IDLE;
                end else if (accept_c) begin
                    if_valid_d = 1'b0;
                end
            end
            default: state_d = IDLE;
        endcase

        halted_d = (state_d == HALT);
    end

    assign bus.im_addr  = pc_q;
    assign bus.im_cs    = load_c;
    assign bus.if_valid = if_valid_q;
    assign bus.if_instr = if_instr_q;
    assign bus.if_pc    = if_pc_q;
    assign bus.halted   = halted_q;
endmodule

// File: tb/tb_instr_fetch_unit.sv
// Directed checks of the fetch unit: one instance wrapping, one halting at end of memory.
module tb_instr_fetch_unit;
    logic clk = 1'b0;
    logic rst_a, rst_b;
    int   total = 0;
    int   bad   = 0;

    logic [31:0] mem [0:3] = '{32'h002000B3, 32'h000100B3, 32'h00308133, 32'h001101B3};

    instr_fetch_unit_if #(.ADDR_W(2), .DATA_W(32)) a_if ();
    instr_fetch_unit_if #(.ADDR_W(2), .DATA_W(32)) b_if ();

    instr_fetch_unit #(.ADDR_W(2), .DATA_W(32), .NUM_INSTR(4), .WRAP(1)) dut_a (
        .clk(clk), .rst(rst_a), .bus(a_if)
    );
    instr_fetch_unit #(.ADDR_W(2), .DATA_W(32), .NUM_INSTR(4), .WRAP(0)) dut_b (
        .clk(clk), .rst(rst_b), .bus(b_if)
    );

    // Combinational memory returning 0 while deselected
    assign a_if.im_data = a_if.im_cs ? mem[a_if.im_addr] : 32'h0;
    assign b_if.im_data = b_if.im_cs ? mem[b_if.im_addr] : 32'h0;

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic chk_a(input string tag, input logic v, input logic [31:0] instr, input logic [1:0] pc);
        chk({tag, ".valid"}, 32'(a_if.if_valid), 32'(v));
        if (v) begin
            chk({tag, ".instr"}, a_if.if_instr, instr);
            chk({tag, ".pc"}, 32'(a_if.if_pc), 32'(pc));
        end
    endtask

    task automatic chk_b(input string tag, input logic v, input logic [31:0] instr, input logic [1:0] pc);
        chk({tag, ".valid"}, 32'(b_if.if_valid), 32'(v));
        if (v) begin
            chk({tag, ".instr"}, b_if.if_instr, instr);
            chk({tag, ".pc"}, 32'(b_if.if_pc), 32'(pc));
        end
    endtask

    initial begin
        logic [31:0] exp_stream [0:4];
        logic [1:0]  exp_pc     [0:4];
        exp_stream = '{32'h002000B3, 32'h000100B3, 32'h00308133, 32'h001101B3, 32'h002000B3};
        exp_pc     = '{2'd0, 2'd1, 2'd2, 2'd3, 2'd0};

        rst_a = 1'b1; a_if.run = 1'b0; a_if.if_ready = 1'b1; a_if.br_valid = 1'b0; a_if.br_target = 2'd0;
        rst_b = 1'b1; b_if.run = 1'b0; b_if.if_ready = 1'b1; b_if.br_valid = 1'b0; b_if.br_target = 2'd0;

        // Reset state
        tick();
        chk("rst.valid", 32'(a_if.if_valid), 32'd0);
        chk("rst.instr", a_if.if_instr, 32'd0);
        chk("rst.pc", 32'(a_if.if_pc), 32'd0);
        chk("rst.halted", 32'(a_if.halted), 32'd0);
        chk("rst.im_cs", 32'(a_if.im_cs), 32'd0);
        chk("rst.im_addr", 32'(a_if.im_addr), 32'd0);

        // Streaming with wrap
        rst_a = 1'b0; a_if.run = 1'b1; #1;
        chk("stream.idle_cs", 32'(a_if.im_cs), 32'd0);
        tick();
        chk_a("stream.first_edge", 1'b0, 32'h0, 2'd0);
        chk("stream.cs0", 32'(a_if.im_cs), 32'd1);
        chk("stream.addr0", 32'(a_if.im_addr), 32'd0);
        for (int i = 0; i < 5; i++) begin
            tick();
            chk_a($sformatf("stream[%0d]", i), 1'b1, exp_stream[i], exp_pc[i]);
            chk($sformatf("stream[%0d].cs", i), 32'(a_if.im_cs), 32'd1);
        end

        // Backpressure on if_pc=1
        tick();
        chk_a("bp.pre", 1'b1, 32'h000100B3, 2'd1);
        a_if.if_ready = 1'b0; #1;
        for (int i = 0; i < 3; i++) begin
            chk($sformatf("bp[%0d].cs", i), 32'(a_if.im_cs), 32'd0);
            tick();
            chk_a($sformatf("bp[%0d]", i), 1'b1, 32'h000100B3, 2'd1);
            chk($sformatf("bp[%0d].addr", i), 32'(a_if.im_addr), 32'd2);
        end
        a_if.if_ready = 1'b1; #1;
        chk("bp.release_cs", 32'(a_if.im_cs), 32'd1);
        tick();
        chk_a("bp.next", 1'b1, 32'h00308133, 2'd2);

        // Redirect while if_pc=0 is being accepted
        tick();
        chk_a("br.pre3", 1'b1, 32'h001101B3, 2'd3);
        tick();
        chk_a("br.pre0", 1'b1, 32'h002000B3, 2'd0);
        a_if.br_valid = 1'b1; a_if.br_target = 2'd3; #1;
        chk("br.cs", 32'(a_if.im_cs), 32'd0);
        tick();
        a_if.br_valid = 1'b0;
        chk_a("br.flush", 1'b0, 32'h0, 2'd0);
        chk("br.addr", 32'(a_if.im_addr), 32'd3);
        tick();
        chk_a("br.target", 1'b1, 32'h001101B3, 2'd3);
        tick();
        chk_a("br.after", 1'b1, 32'h002000B3, 2'd0);

        // Run stop with a held word
        a_if.run = 1'b0; a_if.if_ready = 1'b0; #1;
        chk("stop.cs", 32'(a_if.im_cs), 32'd0);
        tick();
        chk_a("stop.hold0", 1'b1, 32'h002000B3, 2'd0);
        tick();
        chk_a("stop.hold1", 1'b1, 32'h002000B3, 2'd0);
        a_if.if_ready = 1'b1; #1;
        tick();
        chk_a("stop.drain", 1'b0, 32'h0, 2'd0);
        chk("stop.idle_cs", 32'(a_if.im_cs), 32'd0);
        a_if.run = 1'b1; #1;
        chk("resume.idle_cs", 32'(a_if.im_cs), 32'd0);
        tick();
        chk_a("resume.bubble", 1'b0, 32'h0, 2'd0);
        chk("resume.cs", 32'(a_if.im_cs), 32'd1);
        chk("resume.addr", 32'(a_if.im_addr), 32'd1);
        tick();
        chk_a("resume.word", 1'b1, 32'h000100B3, 2'd1);

        // Reset during a stall with pc=2
        a_if.if_ready = 1'b0; #1;
        tick();
        chk_a("mrst.stall", 1'b1, 32'h000100B3, 2'd1);
        chk("mrst.pc2", 32'(a_if.im_addr), 32'd2);
        rst_a = 1'b1;
        tick();
        rst_a = 1'b0; #1;
        chk("mrst.valid", 32'(a_if.if_valid), 32'd0);
        chk("mrst.instr", a_if.if_instr, 32'd0);
        chk("mrst.pc", 32'(a_if.if_pc), 32'd0);
        chk("mrst.addr", 32'(a_if.im_addr), 32'd0);
        chk("mrst.cs", 32'(a_if.im_cs), 32'd0);
        a_if.if_ready = 1'b1;
        tick();
        chk("mrst.fetch_cs", 32'(a_if.im_cs), 32'd1);
        tick();
        chk_a("mrst.first", 1'b1, 32'h002000B3, 2'd0);

        // Halt at end of memory on the non-wrapping instance
        rst_b = 1'b0; b_if.run = 1'b1;
        tick();
        for (int i = 0; i < 4; i++) begin
            tick();
            chk_b($sformatf("halt.stream[%0d]", i), 1'b1, exp_stream[i], exp_pc[i]);
        end
        chk("halt.halted", 32'(b_if.halted), 32'd1);
        chk("halt.cs", 32'(b_if.im_cs), 32'd0);
        tick();
        chk_b("halt.drained", 1'b0, 32'h0, 2'd0);
        chk("halt.still", 32'(b_if.halted), 32'd1);
        tick();
        chk("halt.still2", 32'(b_if.halted), 32'd1);
        chk("halt.cs2", 32'(b_if.im_cs), 32'd0);
        b_if.br_valid = 1'b1; b_if.br_target = 2'd1; #1;
        chk("halt.br_cs", 32'(b_if.im_cs), 32'd0);
        tick();
        b_if.br_valid = 1'b0; #1;
        chk("halt.exit", 32'(b_if.halted), 32'd0);
        chk_b("halt.exit_flush", 1'b0, 32'h0, 2'd0);
        chk("halt.exit_cs", 32'(b_if.im_cs), 32'd1);
        chk("halt.exit_addr", 32'(b_if.im_addr), 32'd1);
        tick();
        chk_b("halt.resume", 1'b1, 32'h000100B3, 2'd1);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
